parity_scan_ctrl: RTL and testbench
===================================

// Module: parity_scan_ctrl
// PURPOSE
//   Sequencer that time-shares one 4-bit parity_flag unit to compute the
//   parity and zero flags of a wider ALU result. It captures a word on
//   start, drives it nibble by nibble (LSB nibble first) into the shared
//   unit, and accumulates the unit's PF. It reports word-level PF/ZF with
//   a one-cycle done pulse. It sits between the ALU result register and
//   the flag register.
// PARAMETERS
//   NIBBLES  4  number of 4-bit nibbles per word (>=1); word width = 4*NIBBLES
// PORTS
//   clk         in   1          single clock, rising edge
//   rst         in   1          synchronous, active-high reset
//   start       in   1          request scan of word; honoured only in IDLE
//   word        in   4*NIBBLES  result to flag; sampled on accepted start
//   busy        out  1          1 while in SCAN
//   done        out  1          one-cycle pulse when PF/ZF are updated
//   PF          out  1          1 = even number of ones in word (registered)
//   ZF          out  1          1 = word was all zeros (registered)
//   nib_result  out  4          nibble driven to the shared parity_flag unit
//   nib_pf      in   1          PF from the shared unit, combinational on nib_result
// BEHAVIOUR
//   Contract for the shared unit: nib_pf=1 when nib_result has an even
//     count of ones. The path is purely combinational and is sampled in
//     the same cycle.
//   Reset (synchronous, rst=1 at posedge): state=IDLE, busy=0, done=0,
//     PF=0, ZF=0, nib_result=0, internal count/accumulators cleared.
//     Reset wins over all other inputs.
//   FSM states: IDLE, SCAN, DONE.
//     IDLE: if start=1, capture word into word_q, set idx=0, acc_odd=0,
//       acc_nz=0, and go to SCAN. Otherwise stay.
//     SCAN: nib_result = word_q[4*idx+3 : 4*idx].
//       Each cycle: acc_odd ^= ~nib_pf; acc_nz |= |nib_result.
//       If idx==NIBBLES-1, go to DONE and load PF <= ~(acc_odd ^ ~nib_pf)
//       and ZF <= ~(acc_nz | |nib_result), using the final nibble's values.
//       Otherwise idx <= idx+1.
//     DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
//   Latency: start is sampled at edge 0. SCAN occupies cycles 1..NIBBLES.
//     done is high in cycle NIBBLES+1. The next start is accepted at the
//     end of that cycle at the earliest (from IDLE only).
//   busy = (state==SCAN). nib_result = 0 outside SCAN.
//   PF/ZF change only on entry to DONE. They hold their value through
//     IDLE and the next scan, until the next DONE.
//   start while in SCAN or DONE is ignored (not queued). word changes
//     after capture have no effect.
//   idx width = max(1, $clog2(NIBBLES)). idx never exceeds NIBBLES-1
//     (no wrap). With NIBBLES=1, SCAN lasts exactly one cycle.
//   Reset mid-SCAN aborts the scan. No done pulse is produced, and PF/ZF
//     are forced to 0.
// TESTING
//   1 Reset: hold rst 2 cycles -> busy=0, done=0, PF=0, ZF=0, nib_result=4'h0.
//   2 word=16'h0000, start 1 cycle -> nib_result 0,0,0,0 in cycles 1-4;
//     done=1 in cycle 5; PF=1, ZF=1.
//   3 word=16'h0001 -> PF=0, ZF=0; word=16'hFFFF -> PF=1, ZF=0;
//     word=16'h8421 -> nib_result 1,2,4,8 in order; PF=1, ZF=0.
//   4 start=1 held during SCAN with word=16'h0007 presented mid-scan ->
//     only the original 16'h8421 is flagged, exactly one done; a new scan
//     starts only after returning to IDLE.
//   5 rst asserted in cycle 2 of a scan of 16'h0001 -> no done pulse,
//     PF=0, ZF=0, busy=0 next cycle; a following scan of 16'h0003 gives PF=1.
//   6 NIBBLES=1: all 16 values 4'h0-4'hF -> done in cycle 2 each;
//     PF = ~^word, ZF = (word==0); results match the parity_flag unit.

Source files
------------

// File: rtl/parity_scan_ctrl.sv
// Word-level parity/zero flag sequencer. It time-shares one external 4-bit
// parity unit by feeding it the captured word one nibble at a time, LSB nibble first.
module parity_scan_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   word,
   output logic                   busy,
   output logic                   done,
   output logic                   PF,
   output logic                   ZF,
   output logic [3:0]             nib_result,
   input  logic                   nib_pf
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [4*NIBBLES-1:0]   word_q;
   logic [IW-1:0]          idx;
   logic                   acc_odd;
   logic                   acc_nz;
   logic                   last_nib;
   logic [3:0]             sel_nib;

   assign last_nib = (idx == LAST);
   assign busy     = (state == SCAN);
   assign done     = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SCAN;
         SCAN:    if (last_nib) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Mux-based nibble select keeps the index arithmetic free of width games.
   always_comb begin
      sel_nib = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IW'(i)) sel_nib = word_q[4*i +: 4];
      end
   end

   always_comb begin
      nib_result = 4'h0;
      if (state == SCAN) nib_result = sel_nib;
   end

   // The final nibble's parity/zero contribution is folded in directly so the
   // flags are ready on entry to DONE without an extra cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         idx     <= '0;
         acc_odd <= 1'b0;
         acc_nz  <= 1'b0;
         PF      <= 1'b0;
         ZF      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  word_q  <= word;
                  idx     <= '0;
                  acc_odd <= 1'b0;
                  acc_nz  <= 1'b0;
               end
            end
            SCAN: begin
               acc_odd <= acc_odd ^ ~nib_pf;
               acc_nz  <= acc_nz | (|nib_result);
               if (last_nib) begin
                  PF <= ~(acc_odd ^ ~nib_pf);
                  ZF <= ~(acc_nz | (|nib_result));
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Self-checking bench for parity_scan_ctrl: a 4-nibble and a 1-nibble instance,
// each paired with a behavioural parity unit, checked against a word-level model.
module tb_parity_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] word;
   logic        busy, done, PF, ZF, nib_pf;
   logic [3:0]  nib_result;

   logic        start1;
   logic [3:0]  word1;
   logic        busy1, done1, PF1, ZF1, nib_pf1;
   logic [3:0]  nib_result1;

   int compared   = 0;
   int mismatched = 0;
   logic expPf = 1'b0;
   logic expZf = 1'b0;

   always #5 clk = ~clk;

   // Shared parity unit: 1 when the nibble holds an even count of ones.
   assign nib_pf  = ~^nib_result;
   assign nib_pf1 = ~^nib_result1;

   parity_scan_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .word(word),
      .busy(busy), .done(done), .PF(PF), .ZF(ZF),
      .nib_result(nib_result), .nib_pf(nib_pf)
   );

   parity_scan_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .word(word1),
      .busy(busy1), .done(done1), .PF(PF1), .ZF(ZF1),
      .nib_result(nib_result1), .nib_pf(nib_pf1)
   );

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic refPf(input logic [15:0] w);
      return ($countones(w) % 2) == 0;
   endfunction

   // Starts a scan of w on the 4-nibble unit and walks it through to DONE.
   // With holdStart, start stays high and word switches to midWord after capture.
   task automatic applyStimulus(input logic [15:0] w, input bit holdStart, input logic [15:0] midWord);
      word  = w;
      start = 1'b1;
      tick();
      if (holdStart) begin
         word = midWord;
      end else begin
         start = 1'b0;
         word  = 16'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput("scan_busy", 16'(busy), 16'd1);
         checkOutput("scan_done", 16'(done), 16'd0);
         checkOutput("scan_nib", 16'(nib_result), (w >> (4 * i)) & 16'hF);
         checkOutput("scan_pf_hold", 16'(PF), 16'(expPf));
         checkOutput("scan_zf_hold", 16'(ZF), 16'(expZf));
         tick();
      end
      expPf = refPf(w);
      expZf = (w == 16'h0);
      checkOutput("done_pulse", 16'(done), 16'd1);
      checkOutput("done_busy", 16'(busy), 16'd0);
      checkOutput("done_pf", 16'(PF), 16'(expPf));
      checkOutput("done_zf", 16'(ZF), 16'(expZf));
      if (!holdStart) begin
         tick();
         checkOutput("idle_done", 16'(done), 16'd0);
         checkOutput("idle_busy", 16'(busy), 16'd0);
         checkOutput("idle_pf", 16'(PF), 16'(expPf));
         checkOutput("idle_zf", 16'(ZF), 16'(expZf));
      end
   endtask

   task automatic applyStimulus1(input logic [3:0] v);
      word1  = v;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checkOutput("n1_busy", 16'(busy1), 16'd1);
      checkOutput("n1_nib", 16'(nib_result1), 16'(v));
      checkOutput("n1_unit", 16'(nib_pf1), 16'(refPf(16'(v))));
      checkOutput("n1_early_done", 16'(done1), 16'd0);
      tick();
      checkOutput("n1_done", 16'(done1), 16'd1);
      checkOutput("n1_pf", 16'(PF1), 16'(refPf(16'(v))));
      checkOutput("n1_zf", 16'(ZF1), 16'(v == 4'h0));
      tick();
      checkOutput("n1_done_clear", 16'(done1), 16'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      word   = 16'h0;
      start1 = 1'b0;
      word1  = 4'h0;
      tick();
      tick();
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_done", 16'(done), 16'd0);
      checkOutput("rst_pf", 16'(PF), 16'd0);
      checkOutput("rst_zf", 16'(ZF), 16'd0);
      checkOutput("rst_nib", 16'(nib_result), 16'd0);
      checkOutput("rst_busy1", 16'(busy1), 16'd0);
      rst = 1'b0;
      tick();

      applyStimulus(16'h0000, 1'b0, 16'h0);
      applyStimulus(16'h0001, 1'b0, 16'h0);
      applyStimulus(16'hFFFF, 1'b0, 16'h0);
      applyStimulus(16'h8421, 1'b0, 16'h0);

      // start held through the scan with a different word presented mid-scan
      applyStimulus(16'h8421, 1'b1, 16'h0007);
      tick();
      checkOutput("hold_idle_busy", 16'(busy), 16'd0);
      checkOutput("hold_idle_done", 16'(done), 16'd0);
      tick();
      start = 1'b0;
      checkOutput("hold_rescan_busy", 16'(busy), 16'd1);
      checkOutput("hold_rescan_nib", 16'(nib_result), 16'h7);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("hold_rescan_nodone", 16'(done), 16'd0);
      end
      tick();
      expPf = refPf(16'h0007);
      expZf = 1'b0;
      checkOutput("hold_rescan_done", 16'(done), 16'd1);
      checkOutput("hold_rescan_pf", 16'(PF), 16'(expPf));
      checkOutput("hold_rescan_zf", 16'(ZF), 16'(expZf));
      tick();

      // reset in cycle 2 of a scan, after a scan that left PF=1
      applyStimulus(16'hFFFF, 1'b0, 16'h0);
      word  = 16'h0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expPf = 1'b0;
      expZf = 1'b0;
      checkOutput("abort_busy", 16'(busy), 16'd0);
      checkOutput("abort_done", 16'(done), 16'd0);
      checkOutput("abort_pf", 16'(PF), 16'd0);
      checkOutput("abort_zf", 16'(ZF), 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("abort_no_done", 16'(done), 16'd0);
      end
      applyStimulus(16'h0003, 1'b0, 16'h0);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(16'($urandom), 1'b0, 16'h0);
      end

      for (int v = 0; v < 16; v++) begin
         applyStimulus1(4'(v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
